// File: rtl/async_fifo_pkg.sv
// Shared async FIFO helpers: default address width and Gray/binary conversions.
// Conversions run on 32-bit values; callers zero-extend and truncate to their pointer width.
package async_fifo_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 4;

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Zero-extended upper bits are harmless: they leave the low bits of the result unchanged.
   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus that changes by at most one bit at a time (Gray pointer).
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;

endmodule

// File: rtl/write_ctrl.sv
// Write-side controller of an async FIFO: write pointer, full/level/overflow flags.
// Define WRITE_CTRL_AFULL_EN to build the registered almost-full compare.
module write_ctrl
   import async_fifo_pkg::*;
#(
   parameter int DLY        = 1,
   parameter int FIFO_WIDTH = 8,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int AFULL_TH   = 2**ADDR_WIDTH - 2
) (
   input  logic                  rst_n_i,
   input  logic                  wr_clk_i,
   input  logic                  wr_en_i,
   input  logic [FIFO_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_WIDTH:0]   rd_gray_ptr_i,
   output logic                  mem_wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [FIFO_WIDTH-1:0] wr_data_o,
   output logic [ADDR_WIDTH:0]   wr_gray_ptr_o,
   output logic                  full_o,
   output logic                  almost_full_o,
   output logic [ADDR_WIDTH:0]   wr_cnt_o,
   output logic                  overflow_o
);

   localparam int PTR_W = ADDR_WIDTH + 1;

   // DLY only matters to simulation-delay flavours of this block; here it is range-checked.
   if (DLY < 0 || AFULL_TH < 0 || AFULL_TH > 2**ADDR_WIDTH || ADDR_WIDTH < 2) begin : g_param_check
      $error("write_ctrl: illegal parameter combination");
   end

   logic [PTR_W-1:0] r_wr_bin;
   logic [PTR_W-1:0] r_wr_gray;
   logic [PTR_W-1:0] r_wr_cnt;
   logic             r_full;
   logic             r_overflow;

   logic             w_wr_accept;
   logic [PTR_W-1:0] w_next_bin;
   logic [PTR_W-1:0] w_next_gray;
   logic [PTR_W-1:0] w_rd_gray_sync;
   logic [PTR_W-1:0] w_rd_bin_sync;
   logic [PTR_W-1:0] w_full_gray;
   logic [PTR_W-1:0] w_next_cnt;

   sync_2ff #(
      .WIDTH (PTR_W)
   ) u_rd_ptr_sync (
      .clk_i   (wr_clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (rd_gray_ptr_i),
      .q_o     (w_rd_gray_sync)
   );

   // Gating with reset drops any write presented while reset is asserted.
   assign w_wr_accept    = wr_en_i & ~r_full & rst_n_i;
   assign w_next_bin     = r_wr_bin + PTR_W'(w_wr_accept);
   assign w_next_gray    = PTR_W'(bin2gray(32'(w_next_bin)));
   assign w_rd_bin_sync  = PTR_W'(gray2bin(32'(w_rd_gray_sync)));
   assign w_next_cnt     = w_next_bin - w_rd_bin_sync;
   assign w_full_gray    = {~w_rd_gray_sync[PTR_W-1 -: 2], w_rd_gray_sync[PTR_W-3:0]};

   always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wr_bin   <= '0;
         r_wr_gray  <= '0;
         r_wr_cnt   <= '0;
         r_full     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_wr_bin   <= w_next_bin;
         r_wr_gray  <= w_next_gray;
         r_wr_cnt   <= w_next_cnt;
         r_full     <= (w_next_gray == w_full_gray);
         r_overflow <= wr_en_i & r_full;
      end
   end

`ifdef WRITE_CTRL_AFULL_EN
   localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_TH);

   logic r_afull;

   always_ff @(posedge wr_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_afull <= 1'b0;
      end else begin
         r_afull <= (w_next_cnt >= AFULL_LVL);
      end
   end

   assign almost_full_o = r_afull;
`else
   assign almost_full_o = 1'b0;
`endif

   assign mem_wr_en_o   = w_wr_accept;
   assign wr_addr_o     = r_wr_bin[ADDR_WIDTH-1:0];
   assign wr_data_o     = wr_data_i;
   assign wr_gray_ptr_o = r_wr_gray;
   assign full_o        = r_full;
   assign wr_cnt_o      = r_wr_cnt;
   assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_write_ctrl.sv
// Randomized self-checking bench for write_ctrl against an occupancy-count reference model.
// Honors WRITE_CTRL_AFULL_EN the same way as the design.
module tb_write_ctrl;

   localparam int AW    = 4;
   localparam int FW    = 8;
   localparam int DEPTH = 2**AW;
   localparam int PMOD  = 2**(AW+1);
   localparam int AFTH  = DEPTH - 2;
`ifdef WRITE_CTRL_AFULL_EN
   localparam bit AFEN = 1'b1;
`else
   localparam bit AFEN = 1'b0;
`endif

   logic          rst_n_i;
   logic          wr_clk_i;
   logic          wr_en_i;
   logic [FW-1:0] wr_data_i;
   logic [AW:0]   rd_gray_ptr_i;
   logic          mem_wr_en_o;
   logic [AW-1:0] wr_addr_o;
   logic [FW-1:0] wr_data_o;
   logic [AW:0]   wr_gray_ptr_o;
   logic          full_o;
   logic          almost_full_o;
   logic [AW:0]   wr_cnt_o;
   logic          overflow_o;

   write_ctrl #(
      .DLY        (1),
      .FIFO_WIDTH (FW),
      .ADDR_WIDTH (AW),
      .AFULL_TH   (AFTH)
   ) dut (
      .rst_n_i       (rst_n_i),
      .wr_clk_i      (wr_clk_i),
      .wr_en_i       (wr_en_i),
      .wr_data_i     (wr_data_i),
      .rd_gray_ptr_i (rd_gray_ptr_i),
      .mem_wr_en_o   (mem_wr_en_o),
      .wr_addr_o     (wr_addr_o),
      .wr_data_o     (wr_data_o),
      .wr_gray_ptr_o (wr_gray_ptr_o),
      .full_o        (full_o),
      .almost_full_o (almost_full_o),
      .wr_cnt_o      (wr_cnt_o),
      .overflow_o    (overflow_o)
   );

   // clock / reset
   initial wr_clk_i = 1'b0;
   always #5 wr_clk_i = ~wr_clk_i;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: counts of writes/reads modulo 2*DEPTH, read count seen two edges late.
   int m_wr;
   int m_s1;
   int m_s2;
   int m_cnt;
   bit m_full;
   bit m_ovf;
   bit m_afull;
   int wr_tot;
   int rd_tot;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int gray_of(input int v);
      return v ^ (v >> 1);
   endfunction

   task automatic model_reset();
      m_wr = 0; m_s1 = 0; m_s2 = 0; m_cnt = 0;
      m_full = 0; m_ovf = 0; m_afull = 0;
      wr_tot = 0; rd_tot = 0;
   endtask

   // One clock cycle: drive, check the combinational write port, clock, check registered outputs.
   task automatic drive(input bit en, input int rd);
      logic [FW-1:0] d;
      bit            acc;
      logic [AW:0]   prev_gray;
      d             = FW'($urandom_range(0, 2**FW - 1));
      wr_en_i       = en;
      wr_data_i     = d;
      rd_gray_ptr_i = (AW+1)'(gray_of(rd % PMOD));
      #1;
      acc = en && !m_full;
      check("mem_wr_en", mem_wr_en_o, acc);
      if (acc) begin
         check("wr_addr", wr_addr_o, m_wr % DEPTH);
         check("wr_data", wr_data_o, d);
      end
      prev_gray = wr_gray_ptr_o;
      @(posedge wr_clk_i);
      m_ovf = en && m_full;
      if (acc) begin
         m_wr = (m_wr + 1) % PMOD;
         wr_tot++;
      end
      m_cnt   = (m_wr - m_s2 + PMOD) % PMOD;
      m_s2    = m_s1;
      m_s1    = rd % PMOD;
      m_full  = (m_cnt == DEPTH);
      m_afull = AFEN && (m_cnt >= AFTH);
      @(negedge wr_clk_i);
      check("wr_gray", wr_gray_ptr_o, gray_of(m_wr));
      check("gray_step", $countones(prev_gray ^ wr_gray_ptr_o), acc ? 1 : 0);
      check("full", full_o, m_full);
      check("wr_cnt", wr_cnt_o, m_cnt);
      check("overflow", overflow_o, m_ovf);
      check("almost_full", almost_full_o, m_afull);
   endtask

   // Asynchronous reset pulse; optionally with a write request pending.
   task automatic do_reset(input bit en);
      wr_en_i       = en;
      rd_gray_ptr_i = '0;
      #2;
      rst_n_i = 1'b0;
      #1;
      check("rst_mem_wr_en", mem_wr_en_o, 0);
      check("rst_wr_addr", wr_addr_o, 0);
      check("rst_wr_gray", wr_gray_ptr_o, 0);
      check("rst_full", full_o, 0);
      check("rst_almost_full", almost_full_o, 0);
      check("rst_wr_cnt", wr_cnt_o, 0);
      check("rst_overflow", overflow_o, 0);
      @(posedge wr_clk_i);
      @(posedge wr_clk_i);
      #1;
      check("rst_hold_mem_wr_en", mem_wr_en_o, 0);
      check("rst_hold_gray", wr_gray_ptr_o, 0);
      @(negedge wr_clk_i);
      wr_en_i = 1'b0;
      rst_n_i = 1'b1;
      model_reset();
      #1;
      check("rel_gray", wr_gray_ptr_o, 0);
   endtask

   initial begin
      rst_n_i       = 1'b1;
      wr_en_i       = 1'b0;
      wr_data_i     = '0;
      rd_gray_ptr_i = '0;
      model_reset();
      #1;
      do_reset(1'b0);

      // Fill an empty FIFO with the reader idle.
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 0);
      check("fill_full", full_o, 1);
      check("fill_cnt", wr_cnt_o, DEPTH);

      // Write into a full FIFO.
      drive(1'b1, 0);
      check("ovf_pulse", overflow_o, 1);
      check("ovf_gray", wr_gray_ptr_o, gray_of(DEPTH));
      drive(1'b0, 0);
      check("ovf_single", overflow_o, 0);

      // Reader frees 4 entries; flags follow only after synchronization.
      rd_tot = 4;
      drive(1'b0, rd_tot);
      drive(1'b0, rd_tot);
      check("drain_still_full", full_o, 1);
      drive(1'b0, rd_tot);
      check("drain_full", full_o, 0);
      check("drain_cnt", wr_cnt_o, DEPTH - 4);

      // Continuous writes with a tracking reader, across the pointer wrap.
      for (int i = 0; i < 40; i++) begin
         rd_tot += $urandom_range(0, wr_tot - rd_tot);
         drive(1'b1, rd_tot);
      end

      // Random write requests and read progress.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) rd_tot += $urandom_range(0, wr_tot - rd_tot);
         drive($urandom_range(0, 3) != 0, rd_tot);
      end

      // Reset in the middle of a write burst.
      do_reset(1'b0);
      for (int i = 0; i < 7; i++) drive(1'b1, 0);
      do_reset(1'b1);
      drive(1'b1, 0);
      check("post_rst_cnt", wr_cnt_o, 1);

      // Almost-full threshold crossing.
      for (int i = 1; i < AFTH - 1; i++) drive(1'b1, 0);
      check("afull_below", almost_full_o, 0);
      drive(1'b1, 0);
      check("afull_at", almost_full_o, AFEN);
      drive(1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/write_ctrl.md
WRITE_CTRL -- requirements
Module: write_ctrl

Interface
REQ-001 SHALL have parameter DLY, default 1, non-blocking assignment delay in time units.
REQ-002 SHALL have parameter FIFO_WIDTH, default 8, data word width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, memory address width; depth = 2**ADDR_WIDTH.
REQ-004 SHALL have parameter AFULL_TH, default 2**ADDR_WIDTH-2, almost-full level threshold.
REQ-005 SHALL have port rst_n_i  input  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_clk_i  input  1  write-domain clock; the only clock.
REQ-007 SHALL have port wr_en_i  input  1  write request.
REQ-008 SHALL have port wr_data_i  input  FIFO_WIDTH  write data.
REQ-009 SHALL have port rd_gray_ptr_i  input  ADDR_WIDTH+1  Gray-coded read pointer from the read domain, asynchronous.
REQ-010 SHALL have port mem_wr_en_o  output  1  memory write strobe.
REQ-011 SHALL have port wr_addr_o  output  ADDR_WIDTH  memory write address.
REQ-012 SHALL have port wr_data_o  output  FIFO_WIDTH  memory write data.
REQ-013 SHALL have port wr_gray_ptr_o  output  ADDR_WIDTH+1  registered Gray write pointer to the read domain.
REQ-014 SHALL have port full_o  output  1  FIFO full.
REQ-015 SHALL have port almost_full_o  output  1  level >= AFULL_TH.
REQ-016 SHALL have port wr_cnt_o  output  ADDR_WIDTH+1  write-side occupancy.
REQ-017 SHALL have port overflow_o  output  1  one-cycle pulse on a write attempted while full.

Function
REQ-018 SHALL accept a write when wr_en_i=1 and full_o=0.
REQ-019 SHALL, on an accepted write, drive mem_wr_en_o=1, wr_addr_o=wr_bin[ADDR_WIDTH-1:0] and wr_data_o=wr_data_i in the same cycle, combinationally.
REQ-020 SHALL advance the binary pointer wr_bin (ADDR_WIDTH+1 bits) by 1 per accepted write and wrap modulo 2**(ADDR_WIDTH+1).
REQ-021 SHALL register wr_gray_ptr_o = next_bin ^ (next_bin>>1), so exactly one bit changes per increment.
REQ-022 SHALL synchronize rd_gray_ptr_i through a 2-flop chain, 2-cycle latency, to produce rd_gray_sync.
REQ-023 SHALL register full_o = 1 when next Gray == {~rd_gray_sync[top two bits], rd_gray_sync[remaining bits]}.
REQ-024 SHALL register wr_cnt_o = next_bin - gray2bin(rd_gray_sync), modulo 2**(ADDR_WIDTH+1), with range 0..2**ADDR_WIDTH.
REQ-025 SHALL pulse overflow_o for one cycle when wr_en_i=1 and full_o=1, leaving the pointer, memory and count unchanged.
REQ-026 SHALL deassert full_o and reduce wr_cnt_o no earlier than 2 cycles after a read-pointer change, so the full/level view is pessimistic.
REQ-027 SHALL, with wr_en_i held while the FIFO fills, write the last free entry and assert full_o in the cycle after that write.

Reset
REQ-028 SHALL, while rst_n_i=0, clear wr_bin, wr_gray_ptr_o, both synchronizer stages, full_o, almost_full_o, wr_cnt_o and overflow_o to 0.
REQ-029 SHALL, on reset mid-write, discard the in-flight write: mem_wr_en_o=0 during reset.
REQ-030 SHALL release reset without glitching wr_gray_ptr_o.

Configuration
REQ-031 SHALL, with WRITE_CTRL_AFULL_EN defined, register almost_full_o = (next wr_cnt >= AFULL_TH).
REQ-032 SHALL, without WRITE_CTRL_AFULL_EN, tie almost_full_o to 0 and omit the compare logic.

Structure
REQ-033 SHALL take bin2gray and gray2bin functions and the default ADDR_WIDTH constant from the shared package async_fifo_pkg.
REQ-034 SHALL implement the read-pointer synchronizer as sub-module sync_2ff, parameterized by width and reset to 0.

Verification
REQ-035 SHALL cover: reset, then 16 writes with ADDR_WIDTH=4 and rd_gray_ptr_i=0 -> wr_addr_o 0..15, full_o=1 after the 16th write, wr_cnt_o=16.
REQ-036 SHALL cover: the FIFO full, then a 17th write -> overflow_o pulses once, wr_gray_ptr_o is unchanged, mem_wr_en_o=0.
REQ-037 SHALL cover: the FIFO full, then rd_gray_ptr_i set to gray(4) -> full_o clears and wr_cnt_o=12 exactly 2-3 cycles later.
REQ-038 SHALL cover: 40 continuous writes with reads tracking -> wr_bin wraps 31->0, Gray changes by one bit per step, and there is no false full.
REQ-039 SHALL cover: WRITE_CTRL_AFULL_EN defined, AFULL_TH=14 -> almost_full_o rises after the 14th write; without the macro, almost_full_o stays 0.
REQ-040 SHALL cover: rst_n_i pulsed low after 7 writes -> all outputs return to 0 asynchronously, and the next write goes to address 0.
